mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single-port unified memory between instruction fetch (i_*) and load/store (d_*).
//  Sits between the fetch/LSU stages of core and the memory array.
//  One transaction outstanding at a time; fixed-latency synchronous memory; per-requester response pulse.
// PARAMETERS
//  AW          16  word-address width (memory index 0..2^AW-1)
//  DW          32  data width
//  MEM_LAT      1  cycles from mem_en to valid mem_rdata; legal 1..4
//  STARVE_MAX   8  consecutive data grants tolerated while i_req pending (fixed-priority mode only)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  i_req      in   1    fetch request; held with i_addr until i_gnt
//  i_addr     in   AW   fetch word address
//  i_gnt      out  1    fetch accepted this cycle
//  i_rvalid   out  1    one-cycle pulse: i_rdata valid
//  i_rdata    out  DW   fetched instruction
//  d_req      in   1    data request; held with d_* until d_gnt
//  d_we       in   1    1 = store, 0 = load
//  d_addr     in   AW   data word address
//  d_wdata    in   DW   store data
//  d_wstrb    in   4    store byte enables
//  d_gnt      out  1    data request accepted this cycle
//  d_rvalid   out  1    one-cycle pulse: load data valid / store complete
//  d_rdata    out  DW   load data
//  mem_en     out  1    memory access strobe
//  mem_we     out  1    memory write enable
//  mem_addr   out  AW   memory address
//  mem_wdata  out  DW   memory write data
//  mem_wstrb  out  4    memory byte enables
//  mem_rdata  in   DW   memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1    1 while state != IDLE
// BEHAVIOUR
//  - FSM: IDLE, WAIT. IDLE: if any req, grant winner (gnt/mem_* combinational, same cycle T) -> WAIT, owner latched.
//  - WAIT: lat_cnt counts 1..MEM_LAT; at MEM_LAT capture mem_rdata into owner's rdata -> IDLE.
//  - Owner's rvalid registered, high exactly cycle T+MEM_LAT+1; new grant allowed in that same cycle.
//  - Throughput: one transaction per MEM_LAT+1 cycles; never two gnts in one cycle; no gnt in WAIT.
//  - mem_* = granted requester's fields when gnt, else all 0. Stores: mem_we=1, mem_wstrb=d_wstrb.
//  - Store ack: d_rvalid pulses at T+MEM_LAT+1; d_rdata holds previous value on stores.
//  - Non-owner's rdata holds; rvalid of non-owner stays 0.
//  - Fixed-priority arbitration: d wins over i.
//    - starve_cnt increments on each d grant while i_req=1.
//    - When starve_cnt==STARVE_MAX and both request, i wins.
//    - starve_cnt clears on i grant or when i_req=0.
//  - Reset (async, rst=0): state IDLE, lat_cnt 0, starve_cnt 0, last_owner=i.
//    - All outputs 0: gnts, rvalids, rdata, mem_*, busy.
//  - Reset mid-WAIT: transaction dropped, no rvalid after release; requester must reissue.
//  - req deasserted after gnt: ignored; transaction still completes and pulses rvalid.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin arbitration.
//    - On simultaneous requests grant the requester not granted last (last_owner flips per grant).
//    - Single requester always wins; starve_cnt held 0.
//  ARB_RR_EN undefined: fixed priority d>i with STARVE_MAX guard as above.
// TESTING (MEM_LAT=1, STARVE_MAX=4 unless noted)
//  1 rst=0 for 2 cycles with i_req=d_req=1 -> all outputs 0, mem_en 0; after release grants start.
//  2 mem[4]=0x00100073, i_req addr 0x0004 at T -> i_gnt=1, mem_en=1, mem_addr=0x0004 at T.
//    -> i_rvalid=1, i_rdata=0x00100073 at T+2; busy=1 at T+1.
//  3 i_req & d_req (load 0x0010) at T, fixed mode -> d_gnt at T, d_rvalid at T+2.
//    -> i_gnt at T+2, i_rvalid at T+4.
//  4 d_req, i_req held high, fixed mode -> d_gnt at T,T+2,T+4,T+6; i_gnt at T+8; d_gnt at T+10.
//  5 store d_addr 0x0020, d_wdata 0xDEADBEEF, d_wstrb 4'b0011 -> mem_we=1, mem_wstrb=0011 at T.
//    -> d_rvalid at T+2; reading 0x0020 back returns low half 0xBEEF merged.
//  6 ARB_RR_EN, both held high -> grants alternate d,i,d,i every 2 cycles.
//    rst=0 at T+1 of a grant -> no rvalid; first grant after release goes to d.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one fixed-latency memory port.
// Define ARB_RR_EN for round-robin; default is data-first with a starvation guard.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam int LW = $clog2(MEM_LAT + 1);

    state_t        state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          own_d_q, own_d_d;
    logic          store_q, store_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          gnt_i, gnt_d;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;
`endif

    // Grants are combinational and suppressed while reset is held.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst && state_q == S_IDLE) begin
            if (i_req && d_req) begin
`ifdef ARB_RR_EN
                gnt_i = last_d_q;
`else
                gnt_i = (starve_q == SW'(STARVE_MAX));
`endif
                gnt_d = !gnt_i;
            end else begin
                gnt_i = i_req;
                gnt_d = d_req;
            end
        end
    end

`ifdef ARB_RR_EN
    always_comb begin
        last_d_d = last_d_q;
        if (gnt_d) begin
            last_d_d = 1'b1;
        end else if (gnt_i) begin
            last_d_d = 1'b0;
        end
    end
`else
    always_comb begin
        starve_d = starve_q;
        if (!i_req || gnt_i) begin
            starve_d = '0;
        end else if (gnt_d) begin
            starve_d = starve_q + SW'(1);
        end
    end
`endif

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        unique case (1'b1)
            gnt_d: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end
            gnt_i: begin
                mem_en   = 1'b1;
                mem_addr = i_addr;
            end
            default: mem_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        own_d_d    = own_d_q;
        store_d    = store_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_i || gnt_d) begin
                    state_d = S_WAIT;
                    lat_d   = LW'(1);
                    own_d_d = gnt_d;
                    store_d = gnt_d && d_we;
                end
            end
            S_WAIT: begin
                if (lat_q == LW'(MEM_LAT)) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                    if (own_d_q) begin
                        d_rvalid_d = 1'b1;
                        if (!store_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            own_d_q    <= 1'b0;
            store_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_RR_EN
            last_d_q   <= 1'b0;
`else
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            own_d_q    <= own_d_d;
            store_q    <= store_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_RR_EN
            last_d_q   <= last_d_d;
`else
            starve_q   <= starve_d;
`endif
        end
    end

    assign i_gnt    = gnt_i;
    assign d_gnt    = gnt_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference.
// Honours ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 1;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory array seen by the DUT, driven only by its mem_* port.
    logic [31:0] phys [256];
    logic [31:0] rd_q;
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) phys[j] <= '0;
            rd_q <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b])
                        phys[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_q <= phys[mem_addr[7:0]];
            end
        end
    end
    assign mem_rdata = rd_q;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: memory contents, next free cycle, outstanding transaction.
    logic [31:0] ref_mem [256];
    int          c = 0;
    int          free_at = 0;
    int          gcyc = -10;
    bit          pend = 0;
    bit          pend_i = 0;
    bit          pend_st = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] ei_rdata = '0;
    logic [31:0] ed_rdata = '0;
    int          starve = 0;
    bit          last_d = 0;
    bit          eg_i, eg_d;

    task automatic model_reset();
        free_at  = 0;
        gcyc     = -10;
        pend     = 0;
        ei_rdata = '0;
        ed_rdata = '0;
        starve   = 0;
        last_d   = 0;
        eg_i     = 0;
        eg_d     = 0;
    endtask

    task automatic sample();
        bit          ev_i, ev_d, e_busy;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [3:0]    ews;
        bit            ewe;
        @(negedge clk);
        if (!rst) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wstrb", mem_wstrb, 0);
            chk("rst_busy", busy, 0);
            model_reset();
            return;
        end
        e_busy = pend && (c > gcyc) && (c < free_at);
        eg_i = 0;
        eg_d = 0;
        if (c >= free_at) begin
            if (i_req && d_req) begin
`ifdef ARB_RR_EN
                eg_i = last_d;
`else
                eg_i = (starve == SMAX);
`endif
                eg_d = !eg_i;
            end else begin
                eg_i = i_req;
                eg_d = d_req;
            end
        end
        ev_i = pend && (c == free_at) && pend_i;
        ev_d = pend && (c == free_at) && !pend_i;
        if (ev_i) ei_rdata = pend_data;
        if (ev_d && !pend_st) ed_rdata = pend_data;
        if (pend && c == free_at) pend = 0;
        ea  = eg_d ? d_addr : (eg_i ? i_addr : '0);
        ewe = eg_d && d_we;
        ewd = eg_d ? d_wdata : '0;
        ews = eg_d ? d_wstrb : '0;
        chk("i_gnt", i_gnt, eg_i);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_en", mem_en, eg_i | eg_d);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_wstrb", mem_wstrb, ews);
        chk("busy", busy, e_busy);
        chk("i_rvalid", i_rvalid, ev_i);
        chk("d_rvalid", d_rvalid, ev_d);
        chk("i_rdata", i_rdata, ei_rdata);
        chk("d_rdata", d_rdata, ed_rdata);
        if (eg_i || eg_d) begin
            pend    = 1;
            gcyc    = c;
            free_at = c + LAT + 1;
            pend_i  = eg_i;
            pend_st = eg_d && d_we;
            if (eg_i) begin
                pend_data = ref_mem[i_addr[7:0]];
            end else if (!d_we) begin
                pend_data = ref_mem[d_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (d_wstrb[b])
                        ref_mem[d_addr[7:0]][8*b +: 8] = d_wdata[8*b +: 8];
            end
            last_d = eg_d;
        end
        if (!i_req || eg_i) starve = 0;
        else if (eg_d) starve++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic idle(input int n);
        i_req = 0;
        d_req = 0;
        repeat (n) step();
    endtask

    task automatic dstore(input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input logic [3:0] s);
        d_req = 1; d_we = 1; d_addr = a; d_wdata = w; d_wstrb = s;
        step();
        d_req = 0;
        step();
        step();
    endtask

    bit          ni_req, nd_req, nd_we;
    logic [AW-1:0] ni_addr, nd_addr;
    logic [DW-1:0] nd_wdata;
    logic [3:0]    nd_wstrb;

    initial begin
        for (int j = 0; j < 256; j++) ref_mem[j] = '0;
        model_reset();
        rst = 0; mem_init = 1;
        i_req = 1; i_addr = 16'h0004;
        d_req = 1; d_we = 0; d_addr = 16'h0010;
        d_wdata = '0; d_wstrb = '0;
        #1;
        step();
        step();
        rst = 1; mem_init = 0;
        sample();
        chk("rel_d_gnt", d_gnt, 1);
        adv();
        d_req = 0;
        step();
        sample();
        chk("rel_i_gnt", i_gnt, 1);
        adv();
        idle(3);

        dstore(16'h0004, 32'h00100073, 4'hF);
        i_req = 1; i_addr = 16'h0004;
        sample();
        chk("fetch_gnt", i_gnt, 1);
        chk("fetch_mem_en", mem_en, 1);
        chk("fetch_addr", mem_addr, 16'h0004);
        adv();
        i_req = 0;
        sample();
        chk("fetch_busy", busy, 1);
        adv();
        sample();
        chk("fetch_rvalid", i_rvalid, 1);
        chk("fetch_rdata", i_rdata, 32'h00100073);
        adv();
        idle(2);

        i_req = 1; i_addr = 16'h0004;
        d_req = 1; d_we = 0; d_addr = 16'h0010;
        sample();
        chk("both_d_gnt", d_gnt, 1);
        chk("both_i_gnt0", i_gnt, 0);
        adv();
        d_req = 0;
        step();
        sample();
        chk("both_d_rvalid", d_rvalid, 1);
        chk("both_i_gnt", i_gnt, 1);
        adv();
        i_req = 0;
        step();
        sample();
        chk("both_i_rvalid", i_rvalid, 1);
        adv();
        idle(2);

        i_req = 1; i_addr = 16'h0008;
        d_req = 1; d_we = 0; d_addr = 16'h0010;
`ifdef ARB_RR_EN
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("rr_d_gnt", d_gnt, (k % 4) == 0);
            chk("rr_i_gnt", i_gnt, (k % 4) == 2);
            adv();
        end
`else
        for (int k = 0; k < 12; k++) begin
            sample();
            chk("starve_d_gnt", d_gnt, k == 0 || k == 2 || k == 4 ||
                                       k == 6 || k == 10);
            chk("starve_i_gnt", i_gnt, k == 8);
            adv();
        end
`endif
        idle(3);

        dstore(16'h0020, 32'h11223344, 4'hF);
        d_req = 1; d_we = 1; d_addr = 16'h0020;
        d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        sample();
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_wstrb", mem_wstrb, 4'b0011);
        adv();
        d_req = 0;
        step();
        sample();
        chk("st_ack", d_rvalid, 1);
        adv();
        d_req = 1; d_we = 0; d_addr = 16'h0020;
        step();
        d_req = 0;
        step();
        sample();
        chk("st_merge", d_rdata, 32'h1122BEEF);
        adv();
        idle(2);

        d_req = 1; d_we = 0; d_addr = 16'h0004;
        step();
        rst = 0;
        d_req = 0;
        step();
        step();
        rst = 1;
        i_req = 1; i_addr = 16'h0004;
        d_req = 1; d_we = 0; d_addr = 16'h0008;
        sample();
        chk("mid_no_rvalid", d_rvalid, 0);
        chk("mid_first_d", d_gnt, 1);
        adv();
        d_req = 0;
        step();
        step();
        idle(3);

        ni_req = 0; nd_req = 0; nd_we = 0;
        ni_addr = '0; nd_addr = '0; nd_wdata = '0; nd_wstrb = '0;
        for (int n = 0; n < 800; n++) begin
            sample();
            ni_req = i_req; nd_req = d_req;
            if (!i_req || eg_i) begin
                ni_req  = ($urandom_range(0, 2) != 0);
                ni_addr = AW'($urandom_range(0, 31));
            end
            if (!d_req || eg_d) begin
                nd_req   = ($urandom_range(0, 2) != 0);
                nd_we    = $urandom_range(0, 1) == 1;
                nd_addr  = AW'($urandom_range(0, 31));
                nd_wdata = $urandom;
                nd_wstrb = 4'($urandom_range(0, 15));
            end
            adv();
            i_req = ni_req; i_addr = ni_addr;
            d_req = nd_req; d_we = nd_we; d_addr = nd_addr;
            d_wdata = nd_wdata; d_wstrb = nd_wstrb;
            rst = ($urandom_range(0, 99) != 0);
        end
        rst = 1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
